// File: rtl/fir_coeff_ctrl.sv
// fir_coeff_ctrl: shadow coefficient bank behind a 4-phase strobe/ack port,
// streamed into the FIR coefficient RAM once per armed frame start.
module fir_coeff_ctrl #(
    parameter int                 NUM_COEFF   = 32,
    parameter int                 COEFF_W     = 16,
    parameter int                 CENTER_TAP  = 16,
    parameter logic [COEFF_W-1:0] UNITY       = 16'h0400,
    parameter logic [15:0]        COMMIT_ADDR = 16'hFFFF,
    parameter logic [15:0]        STATUS_ADDR = 16'hFFFE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               axi_wr_strobe_i,
    input  logic               axi_rd_strobe_i,
    input  logic [15:0]        fir_addr_from_axi,
    input  logic [15:0]        fir_coeff_from_axi,
    output logic               axi_wr_ack_o,
    output logic               axi_rd_ack_o,
    output logic [15:0]        rd_data_o,
    input  logic               vs_i,
    output logic               coeff_we_o,
    output logic [7:0]         coeff_addr_o,
    output logic [COEFF_W-1:0] coeff_data_o,
    output logic               busy_o,
    output logic               update_done_o
);

    localparam int IW = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
    localparam logic [7:0] LAST = 8'(NUM_COEFF - 1);

    typedef enum logic [1:0] {IDLE, WAIT_VS, LOAD, DONE} state_t;

    state_t             state;
    logic [7:0]         idx;
    logic [7:0]         nidx;
    logic               pending;
    logic               wr_s1, wr_s, rd_s1, rd_s, vs_d;
    logic [COEFF_W-1:0] shadow [NUM_COEFF];

    logic               addr_hit;
    logic [IW-1:0]      aidx;
    logic [COEFF_W-1:0] wdata;
    logic               wr_fire;
    logic               wr_coeff;
    logic               wr_commit;
    logic               vs_rise;
    logic [COEFF_W-1:0] first_coeff;
    logic [15:0]        rd_next;

    assign addr_hit  = fir_addr_from_axi < 16'(NUM_COEFF);
    assign aidx      = fir_addr_from_axi[IW-1:0];
    assign wdata     = fir_coeff_from_axi[COEFF_W-1:0];
    assign wr_fire   = wr_s & ~axi_wr_ack_o & (state != LOAD);
    assign wr_coeff  = wr_fire & addr_hit;
    assign wr_commit = wr_fire & (fir_addr_from_axi == COMMIT_ADDR);
    assign vs_rise   = vs_i & ~vs_d;
    assign nidx      = idx + 8'd1;

    // A write to entry 0 on the LOAD entry edge is forwarded so the
    // streamed set is the same snapshot as the rest of the bank.
    assign first_coeff = (wr_coeff && aidx == '0) ? wdata : shadow[0];

    always_comb begin
        rd_next = '0;
        if (addr_hit)
            rd_next = 16'(shadow[aidx]);
        else if (fir_addr_from_axi == STATUS_ADDR)
            rd_next = {14'b0, busy_o, pending};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_s1        <= 1'b0;
            wr_s         <= 1'b0;
            rd_s1        <= 1'b0;
            rd_s         <= 1'b0;
            vs_d         <= 1'b0;
            axi_wr_ack_o <= 1'b0;
            axi_rd_ack_o <= 1'b0;
            rd_data_o    <= '0;
            for (int i = 0; i < NUM_COEFF; i++)
                shadow[i] <= (i == CENTER_TAP) ? UNITY : '0;
        end else begin
            wr_s1 <= axi_wr_strobe_i;
            wr_s  <= wr_s1;
            rd_s1 <= axi_rd_strobe_i;
            rd_s  <= rd_s1;
            vs_d  <= vs_i;
            if (wr_fire) begin
                axi_wr_ack_o <= 1'b1;
                if (wr_coeff)
                    shadow[aidx] <= wdata;
            end else if (!wr_s) begin
                axi_wr_ack_o <= 1'b0;
            end
            if (rd_s && !axi_rd_ack_o) begin
                axi_rd_ack_o <= 1'b1;
                rd_data_o    <= rd_next;
            end else if (!rd_s) begin
                axi_rd_ack_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= WAIT_VS;
            pending       <= 1'b1;
            idx           <= '0;
            coeff_we_o    <= 1'b0;
            coeff_addr_o  <= '0;
            coeff_data_o  <= '0;
            busy_o        <= 1'b0;
            update_done_o <= 1'b0;
        end else begin
            update_done_o <= 1'b0;
            if (wr_commit)
                pending <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (pending)
                        state <= WAIT_VS;
                end
                WAIT_VS: begin
                    if (vs_rise) begin
                        state        <= LOAD;
                        idx          <= '0;
                        coeff_we_o   <= 1'b1;
                        coeff_addr_o <= '0;
                        coeff_data_o <= first_coeff;
                        busy_o       <= 1'b1;
                        if (!wr_commit)
                            pending <= 1'b0;
                    end
                end
                LOAD: begin
                    if (idx == LAST) begin
                        state         <= DONE;
                        coeff_we_o    <= 1'b0;
                        busy_o        <= 1'b0;
                        update_done_o <= 1'b1;
                    end else begin
                        idx          <= nidx;
                        coeff_addr_o <= nidx;
                        coeff_data_o <= shadow[nidx[IW-1:0]];
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// tb_fir_coeff_ctrl: directed and random stimulus against an in-bench
// behavioural model of the shadow bank, commit arming and frame loads.
module tb_fir_coeff_ctrl;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_stb = 1'b0;
    logic        rd_stb = 1'b0;
    logic        vs = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdat = '0;
    logic        wr_ack, rd_ack, we, busy, done;
    logic [15:0] rd_data, cdata;
    logic [7:0]  caddr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int we_cnt = 0;
    int fall_cyc = 0;
    int ack_cyc = 0;
    bit busy_q = 0;
    logic [15:0] cap [N];

    always #5 clk = ~clk;

    fir_coeff_ctrl dut (
        .clk(clk), .rst(rst),
        .axi_wr_strobe_i(wr_stb), .axi_rd_strobe_i(rd_stb),
        .fir_addr_from_axi(addr), .fir_coeff_from_axi(wdat),
        .axi_wr_ack_o(wr_ack), .axi_rd_ack_o(rd_ack), .rd_data_o(rd_data),
        .vs_i(vs), .coeff_we_o(we), .coeff_addr_o(caddr),
        .coeff_data_o(cdata), .busy_o(busy), .update_done_o(done)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: shadow bank, pending flag, load window and handshakes
    logic [15:0] m_sh [N];
    logic [15:0] m_snap [N];
    logic [15:0] m_rd;
    bit m_pend, m_ws1, m_ws, m_rs1, m_rs, m_wack, m_rack, m_vsp;
    int m_mode;  // 0 idle, 1 waiting for frame, 2 loading, 3 done pulse
    int m_t;

    task automatic m_reset();
        for (int i = 0; i < N; i++)
            m_sh[i] = (i == 16) ? 16'h0400 : 16'h0000;
        m_pend = 1; m_mode = 1; m_t = 0; m_rd = '0;
        m_ws1 = 0; m_ws = 0; m_rs1 = 0; m_rs = 0;
        m_wack = 0; m_rack = 0; m_vsp = 0;
    endtask

    task automatic m_step();
        bit wf, rf, loading, commit, rise, pend0;
        logic [15:0] rv;
        loading = (m_mode == 2);
        wf = m_ws && !m_wack && !loading;
        rf = m_rs && !m_rack;
        rise = vs && !m_vsp;
        pend0 = m_pend;
        if (addr < N) rv = m_sh[addr];
        else if (addr == 16'hFFFE) rv = {14'b0, loading, pend0};
        else rv = 16'h0000;
        commit = wf && (addr == 16'hFFFF);
        if (wf && addr < N) m_sh[addr] = wdat;
        if (commit) m_pend = 1;
        case (m_mode)
            0: if (pend0) m_mode = 1;
            1: if (rise) begin
                m_mode = 2; m_t = 0; m_snap = m_sh;
                if (!commit) m_pend = 0;
            end
            2: if (m_t == N - 1) m_mode = 3; else m_t++;
            default: m_mode = 0;
        endcase
        m_wack = wf ? 1'b1 : (m_ws ? m_wack : 1'b0);
        if (rf) m_rd = rv;
        m_rack = rf ? 1'b1 : (m_rs ? m_rack : 1'b0);
        m_ws = m_ws1; m_ws1 = wr_stb;
        m_rs = m_rs1; m_rs1 = rd_stb;
        m_vsp = vs;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else m_step();
    end

    always @(posedge clk) cyc++;

    // Per-cycle compare against the model, plus event monitors
    always @(negedge clk) begin
        if (!rst) begin
            chk("wr_ack", wr_ack, m_wack);
            chk("rd_ack", rd_ack, m_rack);
            chk("rd_data", rd_data, m_rd);
            chk("coeff_we", we, m_mode == 2);
            chk("busy", busy, m_mode == 2);
            chk("update_done", done, m_mode == 3);
            if (m_mode == 2) begin
                chk("coeff_addr", caddr, m_t);
                chk("coeff_data", cdata, m_snap[m_t]);
            end
            if (done) done_cnt++;
            if (we) begin
                we_cnt++;
                if (caddr < N) cap[caddr] = cdata;
            end
            if (busy_q && !busy) fall_cyc = cyc;
            busy_q = busy;
        end else begin
            busy_q = 0;
        end
    end

    task automatic wr(input logic [15:0] a, input logic [15:0] d,
                      output int lat);
        @(negedge clk);
        addr = a; wdat = d; wr_stb = 1'b1; lat = 0;
        while (lat < 300) begin
            @(negedge clk);
            lat++;
            if (wr_ack) break;
        end
        ack_cyc = cyc;
        if (!wr_ack) chk("wr_ack_timeout", wr_ack, 1);
        wr_stb = 1'b0;
        for (int i = 0; i < 300 && wr_ack; i++) @(negedge clk);
        chk("wr_ack_release", wr_ack, 0);
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d,
                      output int lat);
        @(negedge clk);
        addr = a; rd_stb = 1'b1; lat = 0;
        while (lat < 300) begin
            @(negedge clk);
            lat++;
            if (rd_ack) break;
        end
        d = rd_data;
        if (!rd_ack) chk("rd_ack_timeout", rd_ack, 1);
        rd_stb = 1'b0;
        for (int i = 0; i < 300 && rd_ack; i++) @(negedge clk);
        chk("rd_ack_release", rd_ack, 0);
    endtask

    task automatic vs_pulse(input int hold);
        @(negedge clk);
        vs = 1'b1;
        repeat (hold) @(negedge clk);
        vs = 1'b0;
    endtask

    task automatic clear_cap();
        for (int i = 0; i < N; i++) cap[i] = 16'hDEAD;
    endtask

    initial begin
        int lat;
        int d0;
        logic [15:0] d;
        clear_cap();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_we", we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_data", rd_data, 16'h0000);
        chk("rst_caddr", caddr, 8'h00);
        chk("rst_cdata", cdata, 16'h0000);

        // First frame loads the reset set
        vs_pulse(2);
        repeat (40) @(negedge clk);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_we_cnt", we_cnt, N);
        chk("t1_cap0", cap[0], 16'h0000);
        chk("t1_cap16", cap[16], 16'h0400);
        chk("t1_cap31", cap[31], 16'h0000);
        rd(16'hFFFE, d, lat);
        chk("t1_status", d, 16'h0000);
        chk("t1_rd_lat", lat, 3);

        // Shadow write and commit
        wr(16'd3, 16'h1234, lat);
        chk("t2_wr_lat", lat, 3);
        wr(16'hFFFF, 16'h5555, lat);
        rd(16'hFFFE, d, lat);
        chk("t2_status", d, 16'h0001);
        clear_cap();
        vs_pulse(1);
        repeat (40) @(negedge clk);
        chk("t2_cap3", cap[3], 16'h1234);
        chk("t2_cap16", cap[16], 16'h0400);

        // Readback and out-of-range addresses
        rd(16'd3, d, lat);
        chk("t3_rd3", d, 16'h1234);
        chk("t3_rd_lat", lat, 3);
        rd(16'd40, d, lat);
        chk("t3_rd40", d, 16'h0000);
        rd(16'h8000, d, lat);
        chk("t3_rd8000", d, 16'h0000);
        wr(16'd40, 16'h7777, lat);
        chk("t3_wr40_lat", lat, 3);
        wr(16'hFFFF, 16'h0000, lat);
        clear_cap();
        vs_pulse(1);
        repeat (40) @(negedge clk);
        chk("t3_cap3", cap[3], 16'h1234);
        chk("t3_cap8", cap[8], 16'h0000);

        // Write stalled by an active load
        wr(16'd5, 16'h1111, lat);
        wr(16'hFFFF, 16'h0000, lat);
        clear_cap();
        vs_pulse(1);
        repeat (4) @(negedge clk);
        chk("t4_busy", busy, 1);
        wr(16'd5, 16'hBEEF, lat);
        chk("t4_ack_after_busy", ack_cyc - fall_cyc, 1);
        chk("t4_cap5_old", cap[5], 16'h1111);
        rd(16'd5, d, lat);
        chk("t4_rd5", d, 16'hBEEF);

        // Reset in the middle of a load
        wr(16'hFFFF, 16'h0000, lat);
        vs_pulse(1);
        for (int i = 0; i < 100 && !(we && caddr == 8'd10); i++)
            @(negedge clk);
        chk("t5_reached_idx10", caddr, 8'd10);
        #2 rst = 1'b1;
        #1;
        chk("t5_we_async", we, 0);
        chk("t5_busy_async", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        rd(16'd5, d, lat);
        chk("t5_rd5_reset", d, 16'h0000);
        clear_cap();
        d0 = done_cnt;
        vs_pulse(1);
        repeat (40) @(negedge clk);
        chk("t5_done", done_cnt - d0, 1);
        chk("t5_cap3", cap[3], 16'h0000);
        chk("t5_cap16", cap[16], 16'h0400);

        // Long vs high: one load per rising edge
        wr(16'hFFFF, 16'h0000, lat);
        d0 = done_cnt;
        @(negedge clk);
        vs = 1'b1;
        repeat (40) @(negedge clk);
        wr(16'hFFFF, 16'h0000, lat);
        repeat (60) @(negedge clk);
        chk("t6_one_load", done_cnt - d0, 1);
        vs = 1'b0;
        repeat (2) @(negedge clk);
        vs = 1'b1;
        repeat (40) @(negedge clk);
        vs = 1'b0;
        chk("t6_two_loads", done_cnt - d0, 2);

        // Random traffic, checked cycle by cycle against the model
        for (int k = 0; k < 60; k++) begin
            int op;
            logic [15:0] a;
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                case ($urandom_range(0, 3))
                    0: a = 16'hFFFF;
                    1: a = 16'($urandom_range(32, 63));
                    default: a = 16'($urandom_range(0, N - 1));
                endcase
                wr(a, 16'($urandom), lat);
            end else if (op <= 6) begin
                case ($urandom_range(0, 3))
                    0: a = 16'hFFFE;
                    1: a = 16'($urandom);
                    default: a = 16'($urandom_range(0, N - 1));
                endcase
                rd(a, d, lat);
            end else begin
                vs_pulse($urandom_range(1, 5));
                repeat ($urandom_range(0, 10)) @(negedge clk);
            end
        end
        repeat (100) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_coeff_ctrl.md
Name: fir_coeff_ctrl

Overview:
- Sits between the CPU strobe/ack register interface and fir_top's coefficient RAM, in the pixel clock domain.
- CPU writes land in a shadow coefficient bank; writing the commit address arms an update.
- At the next frame start (vs_i rising), a sequencer streams the whole shadow bank into the FIR, one coefficient per clock, so taps never change mid-frame.
- Readback of shadow coefficients and controller status goes over the same 4-phase handshake.

Parameters:
- NUM_COEFF, 32: number of FIR coefficients (2..256).
- COEFF_W, 16: coefficient width.
- CENTER_TAP, 16: index loaded with UNITY at reset.
- UNITY, 16'h0400: reset value of CENTER_TAP; every other entry resets to 0.
- COMMIT_ADDR, 16'hFFFF: write here arms a commit (data ignored).
- STATUS_ADDR, 16'hFFFE: read here returns status.

Ports:
- clk  in  1  pixel clock (rx_clk).
- rst  in  1  asynchronous, active-high reset.
- axi_wr_strobe_i  in  1  write request, 4-phase, asynchronous to clk.
- axi_rd_strobe_i  in  1  read request, 4-phase, asynchronous to clk.
- fir_addr_from_axi  in  16  register address, stable while a strobe is high.
- fir_coeff_from_axi  in  16  write data, stable while axi_wr_strobe_i is high.
- axi_wr_ack_o  out  1  write acknowledge.
- axi_rd_ack_o  out  1  read acknowledge.
- rd_data_o  out  16  read data, valid while axi_rd_ack_o is high.
- vs_i  in  1  vertical sync, active-high, synchronous to clk.
- coeff_we_o  out  1  FIR coefficient RAM write enable.
- coeff_addr_o  out  8  FIR coefficient index.
- coeff_data_o  out  COEFF_W  FIR coefficient value.
- busy_o  out  1  high during LOAD.
- update_done_o  out  1  one-cycle pulse after the last coefficient is written.

Behaviour:
- Reset (async): shadow[CENTER_TAP]=UNITY, all other shadow entries 0, pending=1 (the first frame loads a defined set), state=WAIT_VS.
- Reset values of outputs: all acks, coeff_we_o, busy_o and update_done_o are 0; rd_data_o, coeff_addr_o and coeff_data_o are 0.
- Strobe synchronizers: each strobe passes through a 2-FF synchronizer, giving wr_s and rd_s.
- Write handshake:
  - When wr_s=1, ack=0 and state!=LOAD, perform the write and set axi_wr_ack_o=1 on the next edge.
  - The ack holds until wr_s=0 and then clears on the next edge.
  - Strobe-to-ack latency is 3 clocks.
  - While in LOAD, the ack is withheld; the write completes on the first cycle after LOAD exits.
- Write decode:
  - addr<NUM_COEFF: shadow[addr]<=data[COEFF_W-1:0].
  - addr==COMMIT_ADDR: pending<=1.
  - Any other address: acked, no effect.
- Read handshake:
  - Same 4-phase rule, independent of the write path and never stalled.
  - rd_data_o is registered together with ack (latency 3).
  - addr<NUM_COEFF returns shadow[addr], zero-extended.
  - STATUS_ADDR returns {14'b0, busy, pending}.
  - Any other address returns 0.
  - rd_data_o holds its value until the next read.
- vs edge detection: vs_rise = vs_i & ~vs_d (one register).
- State machine:
  - IDLE: pending=1 -> WAIT_VS.
  - WAIT_VS: vs_rise -> LOAD with idx=0 and pending<=0.
  - LOAD: each cycle coeff_we_o=1, coeff_addr_o=idx, coeff_data_o=shadow[idx], then idx++. After idx==NUM_COEFF-1 -> DONE. LOAD lasts exactly NUM_COEFF cycles, and busy_o=1 throughout.
  - DONE: update_done_o=1 for one cycle, then -> IDLE. If pending was set meanwhile, WAIT_VS is re-entered via IDLE.
- Simultaneous events:
  - A commit write landing in the same cycle vs_rise enters LOAD leaves pending=1, so the set is reloaded on the following frame. This is harmless; the contents are identical.
  - vs_rise outside WAIT_VS is ignored.
  - A vs_rise during LOAD does not restart the sequence.
- A write to shadow[k] in WAIT_VS after vs_rise is impossible (LOAD is entered the same edge), so every LOAD streams one consistent snapshot.
- Reset mid-LOAD: all outputs drop asynchronously and the shadow returns to reset contents. The partially loaded FIR is corrected on the next frame because pending=1.
- Widths: coeff_addr_o is zero-extended idx; the 16-bit address is compared at full width.

Test Plan:
1. Release reset, pulse vs_i -> 32 cycles of coeff_we_o with addr 0..31; data 0 except addr 16 = 16'h0400; update_done_o pulses once; status read = 16'h0000.
2. Write addr 3 = 16'h1234, then addr 16'hFFFF; status read = 16'h0001; on vs_i rising, the LOAD at addr 3 shows 16'h1234 and addr 16 still shows 16'h0400.
3. Read addr 3 -> rd_data_o = 16'h1234, ack 3 clocks after strobe; read addr 40 and 16'h8000 -> 16'h0000. Write addr 40 -> ack returned, and the next LOAD is unchanged.
4. Raise wr_strobe (addr 5, 16'hBEEF) during LOAD -> no ack until busy_o falls, then ack within 1 clock; read addr 5 = 16'hBEEF; the current LOAD streams the old addr-5 value.
5. Assert rst at LOAD idx=10 -> coeff_we_o=0 immediately; after release and the next vs_i, the full reset set is loaded again.
6. Hold vs_i high for many cycles with a commit pending -> exactly one LOAD per rising edge; a second commit during the hold loads on the next rising edge only.
